// File: rtl/scatter_stream_pkg.sv
// -----------------------------------------------------------------------------
// scatter_stream_pkg
// Shared definitions for the buffered scatter stream.
//   act_e     : polarity selector for the sel/valid slot vectors
//   act_map() : maps one bit between external polarity and internal
//               active-high.  The mapping is its own inverse, so it works
//               in both directions.
// -----------------------------------------------------------------------------
package scatter_stream_pkg;

   typedef enum logic {
      ACT_LOW  = 1'b0,
      ACT_HIGH = 1'b1
   } act_e;

   function automatic logic act_map(input logic b, input act_e act);
      return (act == ACT_HIGH) ? b : ~b;
   endfunction

endpackage

// File: rtl/scatter_stream_if.sv
// -----------------------------------------------------------------------------
// scatter_stream_if
// Producer push channel and consumer slot channel of scatter_stream.
//   in_valid/in_ready : push handshake (always active-high)
//   in_cnt/in         : element count and packed push data
//   sel/valid/out     : slot request, slot filled, and slot data
//   count             : registered buffer occupancy
// master = producer/consumer side, slave = the buffer.
// -----------------------------------------------------------------------------
interface scatter_stream_if #(
   parameter int DATA  = 32,
   parameter int IN    = 8,
   parameter int OUT   = 16,
   parameter int DEPTH = 16
);
   logic                         in_valid;
   logic                         in_ready;
   logic [$clog2(IN+1)-1:0]      in_cnt;
   logic [IN-1:0][DATA-1:0]      in;
   logic [OUT-1:0]               sel;
   logic [OUT-1:0]               valid;
   logic [OUT-1:0][DATA-1:0]     out;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport master (output in_valid, in_cnt, in, sel,
                   input  in_ready, valid, out, count);
   modport slave  (input  in_valid, in_cnt, in, sel,
                   output in_ready, valid, out, count);
endinterface

// File: rtl/scatter_stream_scatter.sv
// -----------------------------------------------------------------------------
// scatter_stream_scatter
// Combinational rank-based scatter.  Each enabled slot receives the entry
// whose index equals the number of enabled slots below it, provided that
// index is below the number of available entries.
//   rot_i   : entries, oldest first (already rotated by the read pointer)
//   sel_i   : slot request vector, active-high
//   count_i : number of entries available
//   hit_o   : slot filled, active-high
//   data_o  : slot data, zero where not filled
//   pop_o   : number of slots filled = min(popcount(sel_i), count_i)
// -----------------------------------------------------------------------------
module scatter_stream_scatter #(
   parameter int DATA  = 32,
   parameter int OUT   = 16,
   parameter int DEPTH = 16
) (
   input  logic [DEPTH-1:0][DATA-1:0]     rot_i,
   input  logic [OUT-1:0]                 sel_i,
   input  logic [$clog2(DEPTH+1)-1:0]     count_i,
   output logic [OUT-1:0]                 hit_o,
   output logic [OUT-1:0][DATA-1:0]       data_o,
   output logic [$clog2(DEPTH+1)-1:0]     pop_o
);
   localparam int R_W   = $clog2(OUT+1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // rank[j] = number of enabled slots strictly below slot j;
   // rank[OUT] is the total number of requests.
   logic [OUT:0][R_W-1:0] rank;

   always_comb begin
      for (int j = 0; j <= OUT; j++) begin
         rank[j] = '0;
         for (int b = 0; b < j; b++) begin
            rank[j] = rank[j] + R_W'(sel_i[b]);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < OUT; gi++) begin : g_slot
         logic [PTR_W-1:0] idx;
         logic             fits;
         // idx is only meaningful when fits, which implies rank < DEPTH
         assign idx          = PTR_W'(rank[gi]);
         assign fits         = sel_i[gi] && (32'(rank[gi]) < 32'(count_i));
         assign hit_o[gi]    = fits;
         assign data_o[gi]   = fits ? rot_i[idx] : '0;
      end
   endgenerate

   assign pop_o = (32'(rank[OUT]) < 32'(count_i)) ? CNT_W'(rank[OUT]) : count_i;

endmodule

// File: rtl/scatter_stream.sv
// -----------------------------------------------------------------------------
// scatter_stream
// DEPTH-entry circular buffer between a bursty packer and a slot-based
// consumer.  Up to IN elements are pushed per cycle; each cycle the oldest
// entries are scattered, in order, into the slots requested by sel and only
// those entries are popped.  Outputs are combinational from registered state,
// so pushed data appears one cycle after the push.
//   clk     : clock
//   reset_  : asynchronous active-low reset (pointers and count only)
//   flush   : synchronous clear; blocks push and pop in the same cycle
//   bus     : scatter_stream_if slave (push channel, slot channel, count)
// -----------------------------------------------------------------------------
module scatter_stream
   import scatter_stream_pkg::*;
#(
   parameter int   DATA  = 32,
   parameter int   IN    = 8,
   parameter int   OUT   = 16,
   parameter int   DEPTH = 16,
   parameter act_e ACT   = ACT_HIGH
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             flush,
   scatter_stream_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA-1:0]             mem_q [DEPTH];
   logic [PTR_W-1:0]            head_q, head_d;
   logic [PTR_W-1:0]            tail_q, tail_d;
   logic [CNT_W-1:0]            count_q, count_d;

   logic [OUT-1:0]              sel_en;
   logic [OUT-1:0]              hit;
   logic [DEPTH-1:0][DATA-1:0]  rot;
   logic [CNT_W-1:0]            avail;
   logic [CNT_W-1:0]            pop;
   logic [CNT_W-1:0]            push_n;
   logic                        push_fire;

   genvar gi;
   generate
      for (gi = 0; gi < OUT; gi++) begin : g_pol
         assign sel_en[gi]    = act_map(bus.sel[gi], ACT);
         assign bus.valid[gi] = act_map(hit[gi], ACT);
      end
      for (gi = 0; gi < DEPTH; gi++) begin : g_rot
         assign rot[gi] = mem_q[head_q + PTR_W'(gi)];
      end
   endgenerate

   // Hiding the contents during flush disables every slot and forces pop to 0.
   assign avail = flush ? '0 : count_q;

   scatter_stream_scatter #(
      .DATA  (DATA),
      .OUT   (OUT),
      .DEPTH (DEPTH)
   ) u_scatter (
      .rot_i   (rot),
      .sel_i   (sel_en),
      .count_i (avail),
      .hit_o   (hit),
      .data_o  (bus.out),
      .pop_o   (pop)
   );

   // Conservative: ignores the pop happening in the same cycle.
   assign bus.in_ready = (count_q <= CNT_W'(DEPTH - IN));
   assign bus.count    = count_q;

   assign push_n    = (int'(bus.in_cnt) > IN) ? CNT_W'(IN) : CNT_W'(bus.in_cnt);
   assign push_fire = bus.in_valid && bus.in_ready && !flush;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // pop may equal DEPTH; truncation gives the correct wrap
         head_d  = head_q + PTR_W'(pop);
         if (push_fire) begin
            tail_d = tail_q + PTR_W'(push_n);
         end
         count_d = count_q + (push_fire ? push_n : CNT_W'(0)) - pop;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage has no reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_fire) begin
         for (int i = 0; i < IN; i++) begin
            if (CNT_W'(i) < push_n) begin
               mem_q[tail_q + PTR_W'(i)] <= bus.in[i];
            end
         end
      end
   end

endmodule

// File: doc/scatter_stream.md
# scatter_stream

Buffered, sequential successor to the combinational scatter. Producers push up to IN elements per cycle into a DEPTH-entry circular buffer with a ready/valid handshake. Each cycle a consumer presents a slot-request vector `sel`; the oldest buffered elements are scattered, in order, into the enabled slots, and only those elements are popped. Elements that do not fit are held for later cycles rather than dropped. The block sits between a bursty packer (fetch/decode side) and a slot-based consumer (issue/dispatch side).

## Interface
Parameters:
- DATA, 32, element width in bits
- IN, 8, maximum elements pushed per cycle
- OUT, 16, number of output slots
- DEPTH, 16, buffer entries; power of two, DEPTH >= IN
- ACT, `HIGH, polarity of `sel` and `valid` only; handshake signals are always active-high

Ports:
- clk  in  1  clock
- reset_  in  1  reset; one clock; reset is asynchronous and active-low
- flush  in  1  synchronous clear of buffer contents
- in_valid  in  1  push request
- in_ready  out  1  buffer can accept a full IN-element push
- in_cnt  in  $clog2(IN+1)  number of valid elements, packed at in[0..in_cnt-1]
- in  in  [IN][DATA]  push data
- sel  in  OUT  slot request vector, ACT polarity
- valid  out  OUT  slot filled this cycle, ACT polarity
- out  out  [OUT][DATA]  slot data; 0 where not valid
- count  out  $clog2(DEPTH+1)  registered occupancy

## Operation
- State: entry array, head and tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), and registered count.
- Output mapping is combinational from registered state. Let k be the rank of an enabled bit among enabled `sel` bits, counted from bit 0. That slot receives entry (head+k) mod DEPTH when k < count; otherwise it is DISABLE with data 0.
- pop = number of slots driven valid, so pop = min(popcount(sel), count). head += pop.
- in_ready = (count <= DEPTH-IN), computed from registered count only. This is a conservative check and ignores same-cycle pop.
- Push fires when in_valid && in_ready. n = min(in_cnt, IN) elements are written at tail..tail+n-1 and tail += n. in_cnt = 0 is an accepted no-op. in_cnt > IN is clipped to IN.
- Push and pop in the same cycle are both applied: count_next = count + n - pop.
- No bypass: pushed data becomes visible on `out` in the next cycle.
- flush has priority over push and pop. When flush=1:
  - all `valid` are DISABLE and nothing is popped;
  - the push is not accepted, and in_ready still reflects the pre-flush count;
  - next cycle head = tail = count = 0.
- Reset (async assert): head = tail = count = 0. After reset, in_ready = 1, valid = all DISABLE, out = all 0. Entry array contents are not reset.
- Reset asserted mid-burst discards all buffered data. No partial state survives.

## Timing
- Push-to-output latency: 1 cycle.
- Pop takes effect at the same clock edge that the consumer observes `valid`.
- in_ready falls in the cycle after count exceeds DEPTH-IN, and rises in the cycle after count drops to DEPTH-IN or below.
- At full (count = DEPTH), pushes are blocked and output proceeds normally.
- At empty, all slots are DISABLE regardless of `sel`.
- count never exceeds DEPTH. Verification must assert this every cycle.

## Structure
- ENABLE/DISABLE constants come from parammod_stddef.vh, resolved against ACT as in other ParamMod blocks. No new package is needed.
- Optional sub-module: instantiate the existing `scatter` with IN=DEPTH, OUT=OUT and offset tied to 0.
  - Its input is the entry array rotated by head.
  - Its valid output is ANDed with (rank < count).
- The pointer, count and handshake logic lives in this module. Target size is about 150-250 lines.

## Test plan
- Reset and empty:
  - During reset: valid = all DISABLE, out = 0, count = 0.
  - After reset: in_ready = 1.
  - With sel = all ENABLE and the buffer empty: valid = all DISABLE.
- Single push then scatter (IN=8, OUT=16):
  - Push in = {8,7,...,1} with in_cnt=8.
  - Next cycle apply sel = 0x0023: out[0]=1, out[1]=2, out[5]=3, valid = 0x0023.
  - count goes 8 → 5.
- Residual drain:
  - With 8 entries buffered, apply sel = 0x0001 for 8 cycles.
  - out[0] = 1..8 in order; count decrements by 1 each cycle, ending at 0.
- Backpressure with DEPTH=16:
  - Push 8, then push 8, with no sel: count = 16 and in_ready = 0.
  - A third push is held and count stays 16.
  - Apply sel = 0xFFFF: 16 valid, then in_ready = 1 the following cycle.
- Simultaneous push/pop and wrap:
  - Run 1000 random cycles with random in_cnt and sel.
  - Compare against a reference FIFO model, crossing head/tail wrap many times.
  - Check count_next = count + n - pop on every cycle.
- Flush and reset mid-operation:
  - With 12 entries buffered, assert flush together with in_valid: next cycle count = 0 and no push is accepted.
  - Repeat with reset_ pulsed low asynchronously (not edge-aligned): outputs clear immediately.
